// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge
//   Bridges a data-cache line request (4 x 32-bit beats) onto a single-beat
//   memory request/response interface. Reads assemble the line into rsp_data
//   and writes stream the captured line out beat by beat. A failed beat
//   aborts the rest of the line and completes with rsp_bus_error set.
//
//   Optional build macro: DMEM_TIMEOUT_EN
//     Defined:   an 8-bit per-beat watchdog aborts a beat that has waited
//                TIMEOUT_CYCLES cycles for a handshake or a response.
//     Undefined: REQ and WAIT wait indefinitely; TIMEOUT_CYCLES is only
//                range-checked.
//
//   state | meaning
//   IDLE  | waiting for a line request
//   REQ   | presenting the current beat to memory
//   WAIT  | beat accepted, waiting for its response
//   DONE  | one-cycle completion pulse to the cache
`timescale 1ns/1ps

module dcache_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [148:0] req_info,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_bus_error,
  output logic         busy,
  output logic         req_drop,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [23:0]  mem_req_addr,
  output logic         mem_req_we,
  output logic [31:0]  mem_req_wdata,
  input  logic         mem_rsp_valid,
  input  logic [31:0]  mem_rsp_rdata,
  input  logic         mem_rsp_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     beat_q;
  logic [19:0]    line_addr_q;
  logic           is_store_q;
  logic [127:0]   line_data_q;
  logic           err_q;

  logic           rsp_ok;
  logic           rsp_err;
  logic           tmo_hit;
  logic           abort;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dcache_mem_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  // A response only counts while a beat is outstanding.
  assign rsp_ok  = (state_q == S_WAIT) && mem_rsp_valid && !mem_rsp_error;
  assign rsp_err = (state_q == S_WAIT) && mem_rsp_valid &&  mem_rsp_error;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q;

  // Watchdog: restarts on every entry to REQ or WAIT, counts while there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  // The last counted cycle without progress is the abort point.
  assign tmo_hit = ((state_q == S_REQ  && !mem_req_ready) ||
                    (state_q == S_WAIT && !mem_rsp_valid)) &&
                   (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign abort = rsp_err || tmo_hit;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready)  state_d = S_WAIT;
        else if (tmo_hit)   state_d = S_DONE;
      end
      S_WAIT: begin
        if (rsp_ok)         state_d = (beat_q == 2'd3) ? S_DONE : S_REQ;
        else if (abort)     state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, beat sequencing, read-line assembly and error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat_q      <= 2'd0;
      line_addr_q <= 20'd0;
      is_store_q  <= 1'b0;
      line_data_q <= 128'd0;
      rsp_data    <= 128'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            line_addr_q <= req_info[148:129];
            is_store_q  <= req_info[128];
            line_data_q <= req_info[127:0];
            beat_q      <= 2'd0;
            rsp_data    <= 128'd0;
            err_q       <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          if (abort) begin
            rsp_data <= 128'd0;
            err_q    <= 1'b1;
          end else if (rsp_ok) begin
            if (!is_store_q) rsp_data[{beat_q, 5'd0} +: 32] <= mem_rsp_rdata;
            beat_q <= beat_q + 2'd1;
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun flag: any request seen outside IDLE is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_drop <= 1'b0;
    end else if (req_valid && state_q != S_IDLE) begin
      req_drop <= 1'b1;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy          = (state_q != S_IDLE);
    mem_req_valid = (state_q == S_REQ);
    rsp_valid     = (state_q == S_DONE);
    rsp_bus_error = (state_q == S_DONE) && err_q;
    mem_req_addr  = {line_addr_q, beat_q, 2'b00};
    mem_req_we    = is_store_q;
    mem_req_wdata = is_store_q ? line_data_q[{beat_q, 5'd0} +: 32] : 32'd0;
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
`timescale 1ns/1ps

module tb_dcache_mem_bridge;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic [148:0] req_info = '0;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_bus_error;
  logic         busy;
  logic         req_drop;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [23:0]  mem_req_addr;
  logic         mem_req_we;
  logic [31:0]  mem_req_wdata;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_rdata;
  logic         mem_rsp_error;

  dcache_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_info      (req_info),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_bus_error (rsp_bus_error),
    .busy          (busy),
    .req_drop      (req_drop),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_error (mem_rsp_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           lat;
    int           t_req;
  } rsp_exp_t;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_exp_t;

  rsp_exp_t  sb_q[$];
  beat_exp_t beat_q[$];

  // memory model configuration
  int          ready_dly = 0;
  int          err_beat  = -1;
  bit          silent    = 1'b0;
  logic [31:0] rd_words [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: accepts beats after ready_dly cycles, answers one cycle later.
  initial begin
    int        wait_cnt;
    bit        due;
    logic [1:0] due_beat;
    logic      due_we;
    beat_exp_t e;
    wait_cnt = 0;
    due = 1'b0;
    due_beat = 2'd0;
    due_we = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0;
    mem_rsp_error = 1'b0;
    forever begin
      @(negedge clock);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'd0;
      mem_rsp_error = 1'b0;
      if (!reset) begin
        wait_cnt = 0;
        due = 1'b0;
      end else if (due) begin
        due = 1'b0;
        if (!silent) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_error = (int'(due_beat) == err_beat);
          mem_rsp_rdata = due_we ? 32'hDEADBEEF : rd_words[due_beat];
        end
      end else if (mem_req_valid) begin
        if (wait_cnt < ready_dly) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_req_ready = 1'b1;
          due = 1'b1;
          due_beat = mem_req_addr[3:2];
          due_we = mem_req_we;
          if (beat_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_unexpected: got request addr %h, required none", mem_req_addr);
          end else begin
            e = beat_q.pop_front();
            chk("beat_addr",  mem_req_addr,  e.addr);
            chk("beat_we",    mem_req_we,    e.we);
            chk("beat_wdata", mem_req_wdata, e.wdata);
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse.
  initial begin
    rsp_exp_t r;
    forever begin
      @(negedge clock);
      if (reset && rsp_valid) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got rsp_valid 1, required 0");
        end else begin
          r = sb_q.pop_front();
          chk("rsp_data",      rsp_data,      r.data);
          chk("rsp_bus_error", rsp_bus_error, r.err);
          if (r.lat >= 0) chk("rsp_latency", cyc - r.t_req, r.lat);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [19:0] line, input logic st, input logic [127:0] data,
                       input logic [127:0] exp_data, input logic exp_err, input int lat,
                       input int nbeats, input bit scored);
    beat_exp_t b;
    rsp_exp_t  r;
    for (int i = 0; i < nbeats; i++) begin
      b.addr  = {line, 2'(i), 2'b00};
      b.we    = st;
      b.wdata = st ? data[32*i +: 32] : 32'd0;
      beat_q.push_back(b);
    end
    if (scored) begin
      r.data  = exp_data;
      r.err   = exp_err;
      r.lat   = lat;
      r.t_req = cyc;
      sb_q.push_back(r);
    end
    req_info  = {line, st, data};
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
    end
    chk("beats_left", beat_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"},     rsp_valid,     0);
    chk({tag, "_rsp_bus_error"}, rsp_bus_error, 0);
    chk({tag, "_busy"},          busy,          0);
    chk({tag, "_req_drop"},      req_drop,      0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_req_we"},    mem_req_we,    0);
    chk({tag, "_mem_req_addr"},  mem_req_addr,  0);
    chk({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    chk({tag, "_rsp_data"},      rsp_data,      0);
  endtask

  initial begin
    int lost;
    rd_words[0] = 32'h11111111;
    rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333;
    rd_words[3] = 32'h44444444;

    // reset state
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // zero-wait read of line 0x00010
    issue(20'h00010, 1'b0, 128'd0,
          128'h44444444_33333333_22222222_11111111, 1'b0, 9, 4, 1'b1);
    wait_idle();

    // write line 0x00020, ready held low 3 cycles per beat
    ready_dly = 3;
    issue(20'h00020, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
          128'd0, 1'b0, -1, 4, 1'b1);
    wait_idle();
    ready_dly = 0;

    // read with error on beat 1: two beats only, bus error, zero data
    err_beat = 1;
    issue(20'h00040, 1'b0, 128'd0, 128'd0, 1'b1, -1, 2, 1'b1);
    wait_idle();
    err_beat = -1;

    // read at the top of the address space with a different pattern
    rd_words[0] = 32'h0123ABCD;
    rd_words[1] = 32'hFFFFFFFF;
    rd_words[2] = 32'h00000000;
    rd_words[3] = 32'h80000001;
    issue(20'hFFFFF, 1'b0, 128'd0,
          128'h80000001_00000000_FFFFFFFF_0123ABCD, 1'b0, 9, 4, 1'b1);
    wait_idle();
    chk("req_drop_before_overrun", req_drop, 0);

    // second request during beat 2 is dropped, first completes
    rd_words[0] = 32'h11111111;
    rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333;
    rd_words[3] = 32'h44444444;
    issue(20'h00050, 1'b0, 128'd0,
          128'h44444444_33333333_22222222_11111111, 1'b0, 9, 4, 1'b1);
    repeat (4) @(negedge clock);
    req_info  = {20'hABCDE, 1'b1, 128'h5};
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    wait_idle();
    chk("req_drop_after_overrun", req_drop, 1);

    // reset during WAIT of beat 2 of a write
    issue(20'h00060, 1'b1, 128'h99999999_77777777_55555555_33333333,
          128'd0, 1'b0, -1, 3, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    chk("pre_reset_we", mem_req_we, 1);
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("post_reset_busy", busy, 0);

    // fresh read after reset, request in DONE cycle dropped,
    // request in the following cycle accepted
    issue(20'h00070, 1'b0, 128'd0,
          128'h44444444_33333333_22222222_11111111, 1'b0, 9, 4, 1'b1);
    repeat (8) @(negedge clock);
    chk("done_cycle_rsp_valid", rsp_valid, 1);
    req_info  = {20'h00BAD, 1'b0, 128'd0};
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    chk("after_done_busy", busy, 0);
    chk("done_req_drop", req_drop, 1);
    issue(20'h00080, 1'b0, 128'd0,
          128'h44444444_33333333_22222222_11111111, 1'b0, 9, 4, 1'b1);
    wait_idle();

    // memory never responds
    silent = 1'b1;
`ifdef DMEM_TIMEOUT_EN
    issue(20'h00090, 1'b0, 128'd0, 128'd0, 1'b1, 6, 1, 1'b1);
    wait_idle();
`else
    issue(20'h00090, 1'b0, 128'd0, 128'd0, 1'b0, -1, 1, 1'b0);
    lost = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (!busy) lost++;
    end
    chk("hang_busy_low_cycles", lost, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("hang_recovered_busy", busy, 0);
`endif
    silent = 1'b0;
    chk("final_sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_mem_bridge.md
DCACHE_MEM_BRIDGE -- requirements
Module: dcache_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles waited per beat for handshake or response (8-bit counter, 1..255).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 req_valid  input  1  line request pulse from data cache miss port.
REQ-005 req_info  input  149  [148:129] line address, [128] is_store (1 = evict/write line), [127:0] line data.
REQ-006 rsp_valid  output  1  one-cycle completion pulse to data cache.
REQ-007 rsp_data  output  128  assembled read line; all-zero for writes and errors.
REQ-008 rsp_bus_error  output  1  valid with rsp_valid; 1 = transfer failed.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 req_drop  output  1  sticky flag: a request arrived while busy.
REQ-011 mem_req_valid  output  1  memory beat request.
REQ-012 mem_req_ready  input  1  memory accepts beat when high with mem_req_valid.
REQ-013 mem_req_addr  output  24  byte address {line_addr, beat[1:0], 2'b00}.
REQ-014 mem_req_we  output  1  copy of captured is_store.
REQ-015 mem_req_wdata  output  32  line data[32*beat +: 32] for writes, zero for reads.
REQ-016 mem_rsp_valid  input  1  beat response (read data or write ack).
REQ-017 mem_rsp_rdata  input  32  read word for current beat.
REQ-018 mem_rsp_error  input  1  beat failed; valid with mem_rsp_valid.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; 2-bit beat counter; line = 4 beats of 32 bits, beat 0 = bits [31:0].
REQ-020 IDLE: on req_valid capture req_info, clear beat and rsp_data, go REQ; otherwise stay.
REQ-021 REQ: mem_req_valid=1 with addr/we/wdata stable; on mem_req_ready go WAIT, else hold REQ.
REQ-022 WAIT: on mem_rsp_valid with error=0, reads write mem_rsp_rdata into rsp_data[32*beat +: 32]; beat 3 -> DONE, else beat+1 -> REQ.
REQ-023 WAIT: mem_rsp_valid with mem_rsp_error=1 aborts remaining beats, clears rsp_data, sets error flag, goes DONE.
REQ-024 DONE: rsp_valid=1 and rsp_bus_error=error flag for exactly one cycle, then IDLE with error flag cleared.
REQ-025 rsp_valid, rsp_bus_error, mem_req_valid are decoded from registered state only; no combinational path from any input.
REQ-026 Zero-wait memory (ready always 1, response one cycle after accept): rsp_valid exactly 9 cycles after req_valid.
REQ-027 mem_rsp_valid outside WAIT is ignored; memory never responds in the acceptance cycle.
REQ-028 req_valid while busy=1 is ignored and sets req_drop; req_drop clears only on reset.
REQ-029 req_valid in DONE cycle is ignored (busy=1); a new request is accepted the cycle after DONE.

Reset
REQ-030 Reset asserted at any time, mid-beat included, immediately forces IDLE, beat=0, rsp_data=0, and rsp_valid, rsp_bus_error, busy, req_drop, mem_req_valid, mem_req_we all 0; mem_req_addr and mem_req_wdata 0.
REQ-031 No response is produced for a transfer interrupted by reset.

Configuration
REQ-032 Macro DMEM_TIMEOUT_EN defined: 8-bit counter clears on entering REQ or WAIT and increments each cycle there; reaching TIMEOUT_CYCLES without handshake or response aborts to DONE with rsp_bus_error=1, rsp_data=0.
REQ-033 DMEM_TIMEOUT_EN undefined: no counter; REQ and WAIT wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-034 Read line 0x00010, zero-wait memory returning words 0x11111111..0x44444444 -> addrs 0x000100/104/108/10C, rsp_valid 9 cycles after request, rsp_data=0x44444444_33333333_22222222_11111111, error=0.
REQ-035 Write line 0x00020 data 0xDDDD..._AAAA..., ready held low 3 cycles per beat -> we=1, wdata beat order AAAA/BBBB/CCCC/DDDD, rsp_data=0, error=0.
REQ-036 Read with mem_rsp_error=1 on beat 1 -> exactly 2 requests issued, rsp_valid with rsp_bus_error=1, rsp_data=0.
REQ-037 Second req_valid during beat 2 -> ignored, req_drop=1, first transfer completes normally.
REQ-038 Reset asserted during WAIT of beat 2 -> all outputs 0 same cycle, no rsp_valid; fresh request afterwards completes in 9 cycles.
REQ-039 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never responds -> rsp_valid with rsp_bus_error=1 after 4 WAIT cycles; without macro, busy stays 1 for 1000 cycles.
